// File: rtl/aec_pkg.sv
// aec_pkg: shared types and helpers for the multi-digit arithmetic
// expression calculator (aec_multi).
//   state_e  - controller states IDLE/RECV/CONV/EVAL/DONE
//   op_e     - 2-bit operator code, also the operator-stack entry format
//   ASCII    - character constants recognised by the parser
//   prec()   - binding strength of an operator (higher binds tighter)
//   char2op()- map an operator character to its op code
package aec_pkg;

    typedef enum logic [2:0] {S_IDLE, S_RECV, S_CONV, S_EVAL, S_DONE} state_e;

    // OP_LPAR only lives on the operator stack; it never reaches the postfix queue.
    typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_LPAR = 2'd3} op_e;

    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] NINE  = 8'h39;
    localparam logic [7:0] PLUS  = 8'h2B;
    localparam logic [7:0] MINUS = 8'h2D;
    localparam logic [7:0] MUL   = 8'h2A;
    localparam logic [7:0] LPAR  = 8'h28;
    localparam logic [7:0] RPAR  = 8'h29;
    localparam logic [7:0] EQ    = 8'h3D;
    localparam logic [7:0] SPACE = 8'h20;

    function automatic logic [1:0] prec(input op_e o);
        case (o)
            OP_MUL:         return 2'd2;
            OP_ADD, OP_SUB: return 2'd1;
            default:        return 2'd0;
        endcase
    endfunction

    function automatic op_e char2op(input logic [7:0] c);
        case (c)
            PLUS:    return OP_ADD;
            MINUS:   return OP_SUB;
            MUL:     return OP_MUL;
            default: return OP_LPAR;
        endcase
    endfunction

endpackage

// File: rtl/aec_stack.sv
// aec_stack: parametrised LIFO used for both the operator and operand stacks.
// Ports:
//   clk, rst         - clock, synchronous active-high reset (clears storage)
//   clr_i            - drop all entries (pointer only)
//   push_i, wdata_i  - push a value
//   pop_i / pop2_i   - remove one / two entries
//   top_o, sec_o     - top entry and the one beneath it
//   full_o, empty_o, cnt_o - occupancy
// pop2_i together with push_i replaces the top two entries with wdata_i,
// which lets a binary operator retire in a single cycle. The caller must not
// underflow or overflow the stack; it checks cnt_o/full_o first.
module aec_stack #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         pop2_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             top_o,
    output logic [WIDTH-1:0]             sec_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   cnt_o
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    sp_q, sp_pop, idx1, idx2;

    always_comb begin
        sp_pop = sp_q;
        if (pop2_i)     sp_pop = sp_q - CW'(2);
        else if (pop_i) sp_pop = sp_q - CW'(1);
    end

    assign idx1    = sp_q - CW'(1);
    assign idx2    = sp_q - CW'(2);
    assign top_o   = mem_q[idx1[IW-1:0]];
    assign sec_o   = mem_q[idx2[IW-1:0]];
    assign full_o  = (sp_q == CW'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign cnt_o   = sp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clr_i) begin
            sp_q <= '0;
        end else begin
            if (push_i) mem_q[sp_pop[IW-1:0]] <= wdata_i;
            sp_q <= sp_pop + {{(CW-1){1'b0}}, push_i};
        end
    end

endmodule

// File: rtl/aec_multi.sv
// aec_multi: streamed infix expression calculator (multi-digit operands,
// + - *, parentheses, spaces) returning a signed DATA_W-bit result.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   ready     - first character of an expression is on ascii_in
//   ascii_in  - one expression character per cycle, '=' terminates
//   valid     - one-cycle pulse qualifying result/err (and ovf)
//   result    - wrapped signed result, 0 on error
//   err       - expression error
//   ovf       - only with AEC_OVF_EN: literal or arithmetic signed overflow
//   busy      - expression in progress
// Flow: RECV buffers characters, CONV runs shunting-yard into a postfix token
// queue, EVAL runs the queue on the operand stack, DONE pulses valid.
// Optional feature macro: AEC_OVF_EN.
module aec_multi
    import aec_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int MAX_LEN   = 32,
    parameter int STK_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready,
    input  logic [7:0]        ascii_in,
    output logic              valid,
    output logic [DATA_W-1:0] result,
    output logic              err,
`ifdef AEC_OVF_EN
    output logic              ovf,
`endif
    output logic              busy
);
    localparam int LW  = $clog2(MAX_LEN+1);
    localparam int BIW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int SCW = $clog2(STK_DEPTH+1);

    typedef struct packed {
        logic              is_op;
        op_e               op;
        logic [DATA_W-1:0] value;
    } tok_t;

    state_e            state_q, state_d;
    logic [7:0]        buf_q [MAX_LEN];
    tok_t              q_q   [MAX_LEN];
    logic [LW-1:0]     len_q, len_d, rd_q, rd_d, wq_q, wq_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              in_num_q, in_num_d;  // currently accumulating digits
    logic              have_q, have_d;      // a complete left operand precedes
    logic              err_q, err_d;
    logic              valid_q, busy_q, err_o_q;
    logic [DATA_W-1:0] result_q, res_d;

    logic              buf_we, emit, fail;
    logic [LW-1:0]     buf_wa;
    tok_t              emit_tok, tok;
    logic [7:0]        c;
    logic [3:0]        dig;
    logic              is_digit;
    op_e               c_op, op_top;

    logic              op_push, op_pop, op_full, op_empty;
    logic [1:0]        op_wd, op_top_raw, op_sec_unused;
    logic [SCW-1:0]    op_cnt_unused;
    logic              nd_push, nd_pop2, nd_full, nd_empty_unused;
    logic [DATA_W-1:0] nd_wd, nd_top, nd_sec, alu_res;
    logic [SCW-1:0]    nd_cnt;
    logic              stk_clr;

`ifdef AEC_OVF_EN
    logic                  ovf_q, ovf_d, ovf_o_q, alu_ovf;
    logic [DATA_W+3:0]     acc_ext;
    logic [2*DATA_W-1:0]   prod_w;
`endif

    assign c        = buf_q[rd_q[BIW-1:0]];
    assign dig      = c[3:0];
    assign is_digit = (c >= ZERO) && (c <= NINE);
    assign c_op     = char2op(c);
    assign op_top   = op_e'(op_top_raw);
    assign tok      = q_q[rd_q[BIW-1:0]];
    // stacks are held empty between expressions so an aborted run leaves no residue
    assign stk_clr  = (state_q == S_IDLE) || (state_q == S_DONE);

    aec_stack #(.WIDTH(2), .DEPTH(STK_DEPTH)) u_opstk (
        .clk(clk), .rst(rst), .clr_i(stk_clr),
        .push_i(op_push), .pop_i(op_pop), .pop2_i(1'b0), .wdata_i(op_wd),
        .top_o(op_top_raw), .sec_o(op_sec_unused),
        .full_o(op_full), .empty_o(op_empty), .cnt_o(op_cnt_unused)
    );

    aec_stack #(.WIDTH(DATA_W), .DEPTH(STK_DEPTH)) u_ndstk (
        .clk(clk), .rst(rst), .clr_i(stk_clr),
        .push_i(nd_push), .pop_i(1'b0), .pop2_i(nd_pop2), .wdata_i(nd_wd),
        .top_o(nd_top), .sec_o(nd_sec),
        .full_o(nd_full), .empty_o(nd_empty_unused), .cnt_o(nd_cnt)
    );

    // sec is the left operand, top the right one
    always_comb begin
        case (tok.op)
            OP_ADD:  alu_res = nd_sec + nd_top;
            OP_SUB:  alu_res = nd_sec - nd_top;
            default: alu_res = nd_sec * nd_top;
        endcase
    end

`ifdef AEC_OVF_EN
    always_comb begin
        prod_w = {{DATA_W{nd_sec[DATA_W-1]}}, nd_sec} * {{DATA_W{nd_top[DATA_W-1]}}, nd_top};
        case (tok.op)
            OP_ADD:  alu_ovf = (nd_sec[DATA_W-1] == nd_top[DATA_W-1]) &&
                               (alu_res[DATA_W-1] != nd_sec[DATA_W-1]);
            OP_SUB:  alu_ovf = (nd_sec[DATA_W-1] != nd_top[DATA_W-1]) &&
                               (alu_res[DATA_W-1] != nd_sec[DATA_W-1]);
            // product fits only if the upper half plus sign bit is all-equal
            default: alu_ovf = !((&prod_w[2*DATA_W-1:DATA_W-1]) || ~(|prod_w[2*DATA_W-1:DATA_W-1]));
        endcase
        acc_ext = in_num_q ? (({4'b0, acc_q} * (DATA_W+4)'(10)) + {{DATA_W{1'b0}}, dig})
                           : {{DATA_W{1'b0}}, dig};
    end
`endif

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rd_d     = rd_q;
        wq_d     = wq_q;
        acc_d    = acc_q;
        in_num_d = in_num_q;
        have_d   = have_q;
        err_d    = err_q;
        res_d    = '0;
        buf_we   = 1'b0;
        buf_wa   = len_q;
        emit     = 1'b0;
        emit_tok = '{is_op: 1'b0, op: OP_ADD, value: acc_q};
        op_push  = 1'b0;
        op_pop   = 1'b0;
        op_wd    = OP_LPAR;
        nd_push  = 1'b0;
        nd_pop2  = 1'b0;
        nd_wd    = tok.value;
        fail     = 1'b0;
`ifdef AEC_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (ready) begin
                    state_d  = (ascii_in == EQ) ? S_CONV : S_RECV;
                    buf_we   = 1'b1;
                    buf_wa   = '0;
                    len_d    = LW'(1);
                    rd_d     = '0;
                    wq_d     = '0;
                    acc_d    = '0;
                    in_num_d = 1'b0;
                    have_d   = 1'b0;
                    err_d    = 1'b0;
`ifdef AEC_OVF_EN
                    ovf_d    = 1'b0;
`endif
                end
            end
            S_RECV: begin
                if (len_q == LW'(MAX_LEN)) err_d = 1'b1;   // overlong: drop until '='
                else begin
                    buf_we = 1'b1;
                    len_d  = len_q + LW'(1);
                end
                if (ascii_in == EQ) state_d = S_CONV;
            end
            S_CONV: begin
                if (err_q) fail = 1'b1;
                else if (in_num_q && !is_digit) begin
                    // close the pending literal; the current char is handled next cycle
                    emit     = 1'b1;
                    in_num_d = 1'b0;
                end else if (is_digit) begin
                    if (have_q && !in_num_q) fail = 1'b1;
                    else begin
                        acc_d    = in_num_q ? (acc_q * DATA_W'(10) + DATA_W'(dig)) : DATA_W'(dig);
                        in_num_d = 1'b1;
                        have_d   = 1'b1;
                        rd_d     = rd_q + LW'(1);
`ifdef AEC_OVF_EN
                        if (acc_ext > {5'b0, {(DATA_W-1){1'b1}}}) ovf_d = 1'b1;
`endif
                    end
                end else begin
                    case (c)
                        SPACE: rd_d = rd_q + LW'(1);
                        LPAR: begin
                            if (have_q || op_full) fail = 1'b1;
                            else begin
                                op_push = 1'b1;
                                rd_d    = rd_q + LW'(1);
                            end
                        end
                        RPAR: begin
                            if (!have_q || op_empty) fail = 1'b1;
                            else if (op_top == OP_LPAR) begin
                                op_pop = 1'b1;
                                rd_d   = rd_q + LW'(1);
                            end else begin
                                op_pop   = 1'b1;
                                emit     = 1'b1;
                                emit_tok = '{is_op: 1'b1, op: op_top, value: '0};
                            end
                        end
                        PLUS, MINUS, MUL: begin
                            if (!have_q) fail = 1'b1;
                            else if (!op_empty && op_top != OP_LPAR && prec(op_top) >= prec(c_op)) begin
                                op_pop   = 1'b1;
                                emit     = 1'b1;
                                emit_tok = '{is_op: 1'b1, op: op_top, value: '0};
                            end else if (op_full) fail = 1'b1;
                            else begin
                                op_push = 1'b1;
                                op_wd   = c_op;
                                have_d  = 1'b0;
                                rd_d    = rd_q + LW'(1);
                            end
                        end
                        EQ: begin
                            if (!have_q) fail = 1'b1;
                            else if (op_empty) begin
                                state_d = S_EVAL;
                                rd_d    = '0;
                            end else if (op_top == OP_LPAR) fail = 1'b1;
                            else begin
                                op_pop   = 1'b1;
                                emit     = 1'b1;
                                emit_tok = '{is_op: 1'b1, op: op_top, value: '0};
                            end
                        end
                        default: fail = 1'b1;
                    endcase
                end
                if (emit) wq_d = wq_q + LW'(1);
            end
            S_EVAL: begin
                if (rd_q == wq_q) begin
                    if (nd_cnt != SCW'(1)) fail = 1'b1;
                    else begin
                        res_d   = nd_top;
                        state_d = S_DONE;
                    end
                end else if (!tok.is_op) begin
                    if (nd_full) fail = 1'b1;
                    else begin
                        nd_push = 1'b1;
                        rd_d    = rd_q + LW'(1);
                    end
                end else if (nd_cnt < SCW'(2)) fail = 1'b1;
                else begin
                    nd_pop2 = 1'b1;
                    nd_push = 1'b1;
                    nd_wd   = alu_res;
                    rd_d    = rd_q + LW'(1);
`ifdef AEC_OVF_EN
                    if (alu_ovf) ovf_d = 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (fail) begin
            err_d   = 1'b1;
            res_d   = '0;
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            rd_q     <= '0;
            wq_q     <= '0;
            acc_q    <= '0;
            in_num_q <= 1'b0;
            have_q   <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_o_q  <= 1'b0;
            result_q <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                buf_q[i] <= '0;
                q_q[i]   <= '0;
            end
`ifdef AEC_OVF_EN
            ovf_q    <= 1'b0;
            ovf_o_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            rd_q     <= rd_d;
            wq_q     <= wq_d;
            acc_q    <= acc_d;
            in_num_q <= in_num_d;
            have_q   <= have_d;
            err_q    <= err_d;
            if (buf_we) buf_q[buf_wa[BIW-1:0]] <= ascii_in;
            if (emit)   q_q[wq_q[BIW-1:0]]    <= emit_tok;
            // outputs registered so they line up exactly with the DONE state
            valid_q  <= (state_d == S_DONE);
            busy_q   <= (state_d != S_IDLE);
            if (state_d == S_DONE) begin
                result_q <= err_d ? '0 : res_d;
                err_o_q  <= err_d;
            end
`ifdef AEC_OVF_EN
            ovf_q <= ovf_d;
            if (state_d == S_DONE) ovf_o_q <= ovf_d;
`endif
        end
    end

    assign valid  = valid_q;
    assign result = result_q;
    assign err    = err_o_q;
    assign busy   = busy_q;
`ifdef AEC_OVF_EN
    assign ovf    = ovf_o_q;
`endif

endmodule
